// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: redirect input, imem request/response channel
// and the valid/ready hand-off toward IF/ID.
interface fetch_stage_if #(
  parameter int XLEN = 64
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [31:0]     imem_resp_data;
  logic            id_valid;
  logic            id_ready;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] id_pc;

  modport master (
    input  redirect_valid,
    input  redirect_pc,
    output imem_req_valid,
    input  imem_req_ready,
    output imem_req_addr,
    input  imem_resp_valid,
    input  imem_resp_data,
    output id_valid,
    input  id_ready,
    output id_instr,
    output id_pc
  );

  modport slave (
    output redirect_valid,
    output redirect_pc,
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_req_addr,
    output imem_resp_valid,
    output imem_resp_data,
    input  id_valid,
    output id_ready,
    input  id_instr,
    input  id_pc
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch front end: PC, credit-limited imem issue,
// in-flight PC tracking, instruction queue and redirect flush.
module fetch_stage #(
  parameter int              XLEN     = 64,
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic           clk,
  input logic           rst,
  fetch_stage_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int UW = CW + 2;
  localparam logic [UW-1:0] LIMIT = UW'(DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  cnt_t            cnt_q;
  cnt_t            cnt_d;
  cnt_t            out_q;
  cnt_t            out_d;
  cnt_t            drop_q;
  cnt_t            drop_d;
  ptr_t            hd_q;
  ptr_t            hd_d;
  ptr_t            tl_q;
  ptr_t            tl_d;
  ptr_t            fr_q;
  ptr_t            fr_d;
  ptr_t            fw_q;
  ptr_t            fw_d;

  logic [XLEN-1:0] qpc_q  [DEPTH];
  logic [31:0]     qins_q [DEPTH];
  logic [XLEN-1:0] fpc_q  [DEPTH];

  logic [UW-1:0]   used;
  logic            req_ok;
  logic            req_fire;
  logic            rsp_drop;
  logic            rsp_take;
  logic            deq;

  // Every slot is a credit: queued, in flight, or awaiting discard.
  assign used   = UW'(cnt_q) + UW'(out_q) + UW'(drop_q);
  assign req_ok = !rst && !bus.redirect_valid && (used < LIMIT);

  assign req_fire = req_ok && bus.imem_req_ready;
  assign rsp_drop = bus.imem_resp_valid && (drop_q != '0);
  assign rsp_take = bus.imem_resp_valid && (drop_q == '0)
                    && (out_q != '0);
  assign deq      = (cnt_q != '0) && bus.id_ready;

  assign bus.imem_req_valid = req_ok;
  assign bus.imem_req_addr  = rst ? RESET_PC : pc_q;
  assign bus.id_valid       = !rst && (cnt_q != '0);
  assign bus.id_instr       = qins_q[hd_q];
  assign bus.id_pc          = qpc_q[hd_q];

  always_comb begin
    pc_d   = pc_q;
    cnt_d  = cnt_q;
    out_d  = out_q;
    drop_d = drop_q;
    hd_d   = hd_q;
    tl_d   = tl_q;
    fr_d   = fr_q;
    fw_d   = fw_q;
    if (bus.redirect_valid) begin
      pc_d   = bus.redirect_pc & ~XLEN'(3);
      cnt_d  = '0;
      out_d  = '0;
      // Everything still owed by memory, minus this cycle's reply.
      drop_d = drop_q + out_q
               - CW'(rsp_drop | rsp_take);
      hd_d   = '0;
      tl_d   = '0;
      fr_d   = '0;
      fw_d   = '0;
    end else begin
      if (req_fire) begin
        pc_d = pc_q + XLEN'(4);
      end
      out_d  = out_q + CW'(req_fire) - CW'(rsp_take);
      cnt_d  = cnt_q + CW'(rsp_take) - CW'(deq);
      drop_d = drop_q - CW'(rsp_drop);
      hd_d   = hd_q + AW'(deq);
      tl_d   = tl_q + AW'(rsp_take);
      fr_d   = fr_q + AW'(rsp_take);
      fw_d   = fw_q + AW'(req_fire);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      cnt_q  <= '0;
      out_q  <= '0;
      drop_q <= '0;
      hd_q   <= '0;
      tl_q   <= '0;
      fr_q   <= '0;
      fw_q   <= '0;
    end else begin
      pc_q   <= pc_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      drop_q <= drop_d;
      hd_q   <= hd_d;
      tl_q   <= tl_d;
      fr_q   <= fr_d;
      fw_q   <= fw_d;
    end
  end

  // Payload storage needs no reset; pointers gate visibility.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      fpc_q[fw_q] <= pc_q;
    end
    if (rsp_take) begin
      qpc_q[tl_q]  <= fpc_q[fr_q];
      qins_q[tl_q] <= bus.imem_resp_data;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: DEPTH=2 instance with a
// latency-programmable memory, DEPTH=4 instance for throughput.
module tb_fetch_stage;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fetch_stage_if #(.XLEN(64)) ba ();
  fetch_stage_if #(.XLEN(64)) bb ();

  fetch_stage #(
    .XLEN(64), .DEPTH(2), .RESET_PC(64'h0)
  ) u_dut2 (
    .clk(clk), .rst(rst), .bus(ba)
  );

  fetch_stage #(
    .XLEN(64), .DEPTH(4), .RESET_PC(64'h0)
  ) u_dut4 (
    .clk(clk), .rst(rst), .bus(bb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ins(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [63:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  logic [63:0] req_log[$];
  logic [63:0] fpc[$];
  logic [31:0] fins[$];
  int          ecnt = 0;
  int          mem_lat = 1;
  logic        stray = 1'b0;

  // Memory for DEPTH=2: in-order replies mem_lat edges after accept.
  always @(posedge clk) begin
    ecnt = ecnt + 1;
    #3;
    if (ba.id_valid && ba.id_ready) begin
      fpc.push_back(ba.id_pc);
      fins.push_back(ba.id_instr);
    end
    ba.imem_resp_valid = 1'b0;
    ba.imem_resp_data  = 32'h0;
    if (mq.size() > 0 && mq[0].due <= ecnt + 1) begin
      ba.imem_resp_valid = 1'b1;
      ba.imem_resp_data  = ins(mq[0].addr);
      void'(mq.pop_front());
    end else if (stray) begin
      ba.imem_resp_valid = 1'b1;
      ba.imem_resp_data  = 32'hDEAD_BEEF;
    end
    if (ba.imem_req_valid && ba.imem_req_ready) begin
      mq.push_back('{ba.imem_req_addr, ecnt + 1 + mem_lat});
      req_log.push_back(ba.imem_req_addr);
    end
  end

  logic        b_pend = 1'b0;
  logic [63:0] b_paddr = 64'h0;
  logic [63:0] b_exp = 64'h0;
  int          b_fires = 0;

  // DEPTH=4 side: always-ready, single-cycle memory, linear PC stream.
  always @(posedge clk) begin
    #3;
    if (rst) begin
      b_exp = 64'h0;
    end else if (bb.id_valid && bb.id_ready) begin
      chk("b_pc", bb.id_pc, b_exp);
      chk("b_ins", {32'h0, bb.id_instr}, {32'h0, ins(b_exp)});
      b_exp   = b_exp + 64'd4;
      b_fires = b_fires + 1;
    end
    bb.imem_resp_valid = b_pend;
    bb.imem_resp_data  = ins(b_paddr);
    b_pend  = bb.imem_req_valid && bb.imem_req_ready;
    b_paddr = bb.imem_req_addr;
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("inv2", 64'(u_dut2.cnt_q + u_dut2.out_q
                      + u_dut2.drop_q <= 2), 64'd1);
      chk("inv4", 64'(u_dut4.cnt_q + u_dut4.out_q
                      + u_dut4.drop_q <= 4), 64'd1);
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    mq.delete();
    tick();
    rst = 1'b0;
    req_log.delete();
    fpc.delete();
    fins.delete();
  endtask

  initial begin
    int n0;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    ba.redirect_valid = 1'b0;
    ba.redirect_pc    = 64'h0;
    ba.imem_req_ready = 1'b1;
    ba.id_ready       = 1'b1;
    bb.redirect_valid = 1'b0;
    bb.redirect_pc    = 64'h0;
    bb.imem_req_ready = 1'b1;
    bb.id_ready       = 1'b1;

    // reset state
    tick();
    tick();
    chk("rst_idv", {63'h0, ba.id_valid}, 64'd0);
    chk("rst_rqv", {63'h0, ba.imem_req_valid}, 64'd0);
    chk("rst_addr", ba.imem_req_addr, 64'h0);
    rst = 1'b0;

    // straight-line fetch, L=1
    tick();
    chk("t1_addr", ba.imem_req_addr, 64'h4);
    chk("t1_idv0", {63'h0, ba.id_valid}, 64'd0);
    tick();
    chk("t1_idv1", {63'h0, ba.id_valid}, 64'd1);
    chk("t1_pc0", ba.id_pc, 64'h0);
    chk("t1_ins0", {32'h0, ba.id_instr}, {32'h0, ins(64'h0)});
    repeat (18) tick();
    n0 = fpc.size();
    repeat (12) tick();
    chk("t1_rate2", 64'((fpc.size() - n0) >= 6
                        && (fpc.size() - n0) < 12), 64'd1);
    for (int i = 0; i < 6; i++) begin
      chk("t1_seq", fpc[i], 64'(4 * i));
      chk("t1_ins", {32'h0, fins[i]}, {32'h0, ins(64'(4 * i))});
    end
    n0 = b_fires;
    repeat (12) tick();
    chk("t1_rate4", 64'(b_fires - n0), 64'd12);

    // decode stall
    ba.id_ready = 1'b0;
    do_reset();
    repeat (10) tick();
    chk("t2_nreq", 64'(req_log.size()), 64'd2);
    chk("t2_idv", {63'h0, ba.id_valid}, 64'd1);
    chk("t2_pc", ba.id_pc, 64'h0);
    chk("t2_rqv", {63'h0, ba.imem_req_valid}, 64'd0);
    ba.id_ready = 1'b1;
    repeat (8) tick();
    chk("t2_n", 64'(fpc.size() >= 3), 64'd1);
    chk("t2_s0", fpc[0], 64'h0);
    chk("t2_s1", fpc[1], 64'h4);
    chk("t2_s2", fpc[2], 64'h8);

    // redirect with two in flight, L=3
    mem_lat = 3;
    do_reset();
    tick();
    tick();
    ba.redirect_valid = 1'b1;
    ba.redirect_pc    = 64'h100;
    #1;
    chk("t3_norq", {63'h0, ba.imem_req_valid}, 64'd0);
    tick();
    ba.redirect_valid = 1'b0;
    chk("t3_drop", 64'(u_dut2.drop_q), 64'd2);
    chk("t3_idv", {63'h0, ba.id_valid}, 64'd0);
    repeat (12) tick();
    chk("t3_n", 64'(fpc.size() >= 2), 64'd1);
    chk("t3_r2", req_log[2], 64'h100);
    chk("t3_p0", fpc[0], 64'h100);
    chk("t3_p1", fpc[1], 64'h104);

    // redirect coinciding with response and dequeue, L=1
    mem_lat = 1;
    do_reset();
    tick();
    tick();
    ba.redirect_valid = 1'b1;
    ba.redirect_pc    = 64'h203;
    tick();
    ba.redirect_valid = 1'b0;
    chk("t4_idv", {63'h0, ba.id_valid}, 64'd0);
    chk("t4_cnt", 64'(u_dut2.cnt_q), 64'd0);
    chk("t4_drop", 64'(u_dut2.drop_q), 64'd0);
    chk("t4_out", 64'(u_dut2.out_q), 64'd0);
    repeat (6) tick();
    chk("t4_n", 64'(fpc.size() >= 3), 64'd1);
    chk("t4_p0", fpc[0], 64'h0);
    chk("t4_p1", fpc[1], 64'h200);
    chk("t4_p2", fpc[2], 64'h204);

    // memory backpressure
    ba.imem_req_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_rqv", {63'h0, ba.imem_req_valid}, 64'd1);
      chk("t5_addr", ba.imem_req_addr, 64'h0);
    end
    ba.imem_req_ready = 1'b1;
    tick();
    chk("t5_adv", ba.imem_req_addr, 64'h4);

    // mid-operation reset, then a stray response
    mem_lat = 3;
    ba.id_ready = 1'b0;
    do_reset();
    repeat (4) tick();
    chk("t6_pre", {63'h0, ba.id_valid}, 64'd1);
    rst = 1'b1;
    mq.delete();
    tick();
    rst = 1'b0;
    #1;
    chk("t6_idv", {63'h0, ba.id_valid}, 64'd0);
    chk("t6_addr", ba.imem_req_addr, 64'h0);
    chk("t6_rqv", {63'h0, ba.imem_req_valid}, 64'd1);
    fpc.delete();
    fins.delete();
    stray = 1'b1;
    ba.id_ready = 1'b1;
    tick();
    stray = 1'b0;
    chk("t6_ign", {63'h0, ba.id_valid}, 64'd0);
    chk("t6_out", 64'(u_dut2.out_q), 64'd1);
    repeat (6) tick();
    chk("t6_n", 64'(fpc.size() >= 1), 64'd1);
    chk("t6_p0", fpc[0], 64'h0);
    chk("t6_i0", {32'h0, fins[0]}, {32'h0, ins(64'h0)});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
